// File: rtl/btn_cond_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// Defaults assume the 25 MHz board clock.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } btn_state_t;

    localparam int CLK_HZ = 25_000_000;

    // 20 ms debounce window
    localparam int DEBOUNCE_DEFAULT = CLK_HZ / 50;

    // 5.2 s minimum press stretch
    localparam int HOLD_DEFAULT = (CLK_HZ / 10) * 52;

endpackage

// File: rtl/btn_conditioner_sync2ff.sv
// Generic two-flop synchroniser with asynchronous active-high reset.
// Both stages clear to 0 on reset.
module sync2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Two back-to-back flops to resolve metastability on the async input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= d;
            sync2 <= sync1;
        end
    end

    assign q = sync2;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchroniser, debounce FSM, press/release strobes.
// Define BTN_COND_HOLD_EN to stretch each press for HOLD_CYCLES on signal_out.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int HOLD_CYCLES     = HOLD_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic signal_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic pressed
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [DW-1:0] dcnt;
    logic [DW-1:0] dcnt_nxt;
    logic          press_nxt;
    logic          release_nxt;
    logic          pressed_nxt;
    logic          signal_nxt;
    logic          btn_norm;
    logic          sync2;

    // Normalise so that 1 always means "pressed" before synchronising
    assign btn_norm = btn_raw ^ ACTIVE_LOW;

    sync2ff #(
        .WIDTH(1)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (btn_norm),
        .q  (sync2)
    );

    // Debounce next-state: a level must hold DEBOUNCE_CYCLES samples to count
    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (sync2) begin
                    state_nxt = PRESS_CHK;
                    dcnt_nxt  = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync2) begin
                    state_nxt = IDLE;
                    dcnt_nxt  = '0;
                end else if (dcnt == DLAST) begin
                    state_nxt = PRESSED;
                    dcnt_nxt  = '0;
                    press_nxt = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_nxt = RELEASE_CHK;
                    dcnt_nxt  = '0;
                end
            end
            RELEASE_CHK: begin
                if (sync2) begin
                    state_nxt = PRESSED;
                    dcnt_nxt  = '0;
                end else if (dcnt == DLAST) begin
                    state_nxt   = IDLE;
                    dcnt_nxt    = '0;
                    release_nxt = 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                dcnt_nxt  = '0;
            end
        endcase
        pressed_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
    end

`ifdef BTN_COND_HOLD_EN
    localparam logic [27:0] HOLD_LOAD = 28'(HOLD_CYCLES - 1);

    logic [27:0] hold_cnt;
    logic [27:0] hold_nxt;

    // Reload on every accepted press, otherwise count down and stick at 0
    always_comb begin
        hold_nxt = hold_cnt;
        if (press_pulse) begin
            hold_nxt = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_nxt = hold_cnt - 28'd1;
        end
        signal_nxt = pressed_nxt || (hold_nxt != '0);
    end

    // Hold counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_nxt;
        end
    end
`else
    // Without stretching the hold length has no effect; it is always >= 1
    always_comb begin
        signal_nxt = pressed_nxt && (HOLD_CYCLES > 0);
    end
`endif

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            dcnt          <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            pressed       <= 1'b0;
            signal_out    <= 1'b0;
        end else begin
            state         <= state_nxt;
            dcnt          <= dcnt_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            pressed       <= pressed_nxt;
            signal_out    <= signal_nxt;
        end
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed testbench for btn_conditioner (DEBOUNCE=4, HOLD=20, active-low pin).
// Hold expectations follow BTN_COND_HOLD_EN.
module tb_btn_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b1;
    logic signal_out;
    logic press_pulse;
    logic release_pulse;
    logic pressed;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .signal_out   (signal_out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .pressed      (pressed)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // advance one clock edge, land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string t, input int k,
                           input int e_sig, input int e_pp,
                           input int e_rp, input int e_pr);
        chk($sformatf("%s signal_out k=%0d", t, k), int'(signal_out), e_sig);
        chk($sformatf("%s press_pulse k=%0d", t, k), int'(press_pulse), e_pp);
        chk($sformatf("%s release_pulse k=%0d", t, k), int'(release_pulse), e_rp);
        chk($sformatf("%s pressed k=%0d", t, k), int'(pressed), e_pr);
    endtask

    // reset with the pin released, then let the synchroniser settle
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        btn_raw = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        int npp;
        int e_pr;
        int e_sig;

        // Reset: pin pressed while in reset, outputs must stay 0
        rst = 1'b1;
        btn_raw = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            step();
            chk_all("rst_hold", k, 0, 0, 0, 0);
        end
        btn_raw = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk_all("rst_rel", k, 0, 0, 0, 0);
        end

        // Clean press: pulse and pressed after edge 6
        btn_raw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("clean press_pulse k=%0d", k), int'(press_pulse),
                (k == 6) ? 1 : 0);
            chk($sformatf("clean pressed k=%0d", k), int'(pressed),
                (k >= 6) ? 1 : 0);
            chk($sformatf("clean release_pulse k=%0d", k), int'(release_pulse), 0);
        end
        // Clean release, symmetric latency
        btn_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("clean release_pulse k=%0d", k+100), int'(release_pulse),
                (k == 6) ? 1 : 0);
            chk($sformatf("clean pressed k=%0d", k+100), int'(pressed),
                (k < 6) ? 1 : 0);
            chk($sformatf("clean press_pulse k=%0d", k+100), int'(press_pulse), 0);
        end

        // Bounce: low 3, high 1, then low; single press at edge 10
        do_reset();
        npp = 0;
        for (int k = 0; k < 16; k++) begin
            btn_raw = (k == 3) ? 1'b1 : 1'b0;
            step();
            if (press_pulse) npp++;
            chk($sformatf("bounce press_pulse k=%0d", k), int'(press_pulse),
                (k == 10) ? 1 : 0);
            chk($sformatf("bounce pressed k=%0d", k), int'(pressed),
                (k >= 10) ? 1 : 0);
        end
        chk("bounce pulse_count", npp, 1);

        // Two 8-cycle presses, second one starting while hold is running
        do_reset();
        for (int k = 0; k < 48; k++) begin
            btn_raw = ((k < 8) || (k >= 16 && k < 24)) ? 1'b0 : 1'b1;
            step();
            e_pr = ((k >= 6 && k <= 13) || (k >= 22 && k <= 29)) ? 1 : 0;
`ifdef BTN_COND_HOLD_EN
            e_sig = (k >= 6 && k <= 41) ? 1 : 0;
`else
            e_sig = e_pr;
`endif
            chk_all("hold", k, e_sig,
                    (k == 6 || k == 22) ? 1 : 0,
                    (k == 14 || k == 30) ? 1 : 0,
                    e_pr);
        end

        // Reset in PRESS_CHK at dcnt=2, then a full debounce again
        do_reset();
        btn_raw = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_all("pre_rst", k, 0, 0, 0, 0);
        end
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 0, 0, 0, 0, 0);
        step();
        step();
        chk_all("mid_rst", 1, 0, 0, 0, 0);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            step();
            chk_all("post_rst", k, (k >= 6) ? 1 : 0, (k == 6) ? 1 : 0, 0,
                    (k >= 6) ? 1 : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
